cdc_src_arb_clear_ctrl: RTL

Source-domain controller in front of the clearable two-phase CDC's source port. It round-robin arbitrates NUM_REQ requesters onto the single CDC valid/ready/data port. It holds the grant until the CDC handshake completes. It also sequences warm clears: it quiesces valid, pulses the CDC clear input, waits for the clear-pending indication to finish, and guards the wait with a watchdog.

---
 rtl/cdc_src_arb_clear_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cdc_src_arb_clear_ctrl.sv
// Round-robin arbiter and warm-clear sequencer for the clearable CDC source port.
// Grant is 1 cycle after request valid and is held until cdc_ready_i; clears quiesce valid before pulsing cdc_clear_o.
module cdc_src_arb_clear_ctrl #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDX_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          cdc_valid_o,
  input  logic                          cdc_ready_i,
  output logic [DATA_WIDTH-1:0]         cdc_data_o,
  output logic [IDX_WIDTH-1:0]          cdc_idx_o,
  output logic                          cdc_clear_o,
  input  logic                          cdc_clear_pending_i,
  input  logic                          clear_req_i,
  output logic                          clear_busy_o,
  output logic                          clear_done_o,
  output logic                          clear_timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    BUSY        = 3'd1,
    CLR_QUIESCE = 3'd2,
    CLR_ASSERT  = 3'd3,
    CLR_WAIT    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0] rr_q, rr_d;
  logic                 clr_pend_q, clr_pend_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic                 seen_q, seen_d;

  logic                 arb_found;
  logic [IDX_WIDTH-1:0] arb_idx;
  logic                 in_busy;

  // First valid requester at or after the RR pointer, wrapping.
  always_comb begin
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(rr_q) + i) % NUM_REQ;
      if (!arb_found && req_valid_i[j]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_WIDTH'(j);
      end
    end
  end

  assign in_busy = (state_q == BUSY);

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    clr_pend_d      = clr_pend_q;
    wdog_d          = wdog_q;
    seen_d          = seen_q;
    cdc_clear_o     = 1'b0;
    clear_done_o    = 1'b0;
    clear_timeout_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clear_req_i) clr_pend_d = 1'b1;
        if (clr_pend_q || clear_req_i) begin
          state_d = CLR_QUIESCE;
        end else if (cdc_clear_pending_i) begin
          state_d = IDLE;
        end else if (arb_found) begin
          grant_d = arb_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (clear_req_i) clr_pend_d = 1'b1;
        if (cdc_ready_i) begin
          rr_d    = (grant_q == IDX_LAST) ? '0 : grant_q + IDX_WIDTH'(1);
          state_d = IDLE;
        end else if (clear_req_i) begin
          // Item stays with its requester; pointer untouched so it re-wins first.
          state_d = CLR_QUIESCE;
        end else if (cdc_clear_pending_i) begin
          state_d = IDLE;
        end
      end
      CLR_QUIESCE: begin
        state_d = CLR_ASSERT;
      end
      CLR_ASSERT: begin
        cdc_clear_o = 1'b1;
        clr_pend_d  = 1'b0;
        seen_d      = 1'b0;
        wdog_d      = '0;
        state_d     = CLR_WAIT;
      end
      CLR_WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        seen_d = seen_q | cdc_clear_pending_i;
        if (seen_q && !cdc_clear_pending_i) begin
          clear_done_o = 1'b1;
          state_d      = IDLE;
        end else if (wdog_q == WD_LAST) begin
          clear_timeout_o = 1'b1;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      clr_pend_q <= 1'b0;
      wdog_q     <= '0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      clr_pend_q <= clr_pend_d;
      wdog_q     <= wdog_d;
      seen_q     <= seen_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_ready_o[r] = in_busy && cdc_ready_i && (grant_q == IDX_WIDTH'(r));
    end
  end

  assign cdc_valid_o  = in_busy;
  assign cdc_idx_o    = in_busy ? grant_q : '0;
  assign cdc_data_o   = in_busy ? req_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign clear_busy_o = (state_q == CLR_QUIESCE) || (state_q == CLR_ASSERT) ||
                        (state_q == CLR_WAIT);

  a_clear_no_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    cdc_clear_o |-> !cdc_valid_o);

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));

  // Valid may only be withdrawn by a handshake, a clear request or a remote clear.
  a_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (cdc_valid_o && !cdc_ready_i && !clear_req_i && !cdc_clear_pending_i)
      |=> (cdc_valid_o && $stable(cdc_idx_o)));

endmodule
